psoa_sigmoid_sched: RTL and testbench



---
 rtl/psoa_sigmoid_sched.sv | 175 +++++++++++++++++
 tb/tb_psoa_sigmoid_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psoa_sigmoid_sched.sv
// psoa_sigmoid_sched: round-robin scheduler sharing one psoa_sigmoid unit among N_REQ requesters.
// Negative operands are folded to |x| before issue and the result is mirrored as ONE_Q - f(|x|).
// Optional build macro PSOA_SCHED_STATS_EN adds the stat_ops / stat_busy counters.
module psoa_sigmoid_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SIG_LAT = 1,
  parameter int unsigned ONE_Q   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [16*N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [15:0]              sig_x,
  input  logic [15:0]              sig_fx,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [15:0]              rsp_fx,
  output logic                     idle
`ifdef PSOA_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_busy
`endif
);

  localparam int unsigned IdW   = $clog2(N_REQ);
  localparam int unsigned Depth = SIG_LAT + 1;
  localparam logic [15:0] OneQ  = 16'(ONE_Q);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_q;
  logic [15:0]      sig_x_q;
  logic [Depth-1:0] tag_vld_q;
  logic [Depth-1:0] tag_neg_q;
  logic [IdW-1:0]   tag_id_q [Depth];
  logic             rsp_valid_q;
  logic [IdW-1:0]   rsp_id_q;
  logic [15:0]      rsp_fx_q;

  logic [15:0]      x_arr [N_REQ];
  logic [N_REQ-1:0] grant;
  logic [IdW-1:0]   idx;
  logic [IdW-1:0]   win_id;
  logic [15:0]      win_x;
  logic [15:0]      abs_x;
  logic             neg_x;
  logic             hs;
  logic             pipe_empty;
  logic [15:0]      fx_clamp;

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_xsplit
    assign x_arr[g] = req_x[16*g +: 16];
  end

  // Round-robin search from rr+1; scanning farthest-first lets the nearest valid requester win.
  always_comb begin
    grant  = '0;
    idx    = '0;
    win_id = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = IdW'((int'(rr_q) + k) % int'(N_REQ));
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win_id     = idx;
      end
    end
  end

  assign win_x      = x_arr[win_id];
  assign hs         = |(req_valid & req_ready);
  assign pipe_empty = ~|tag_vld_q;

  // Fold the operand onto x >= 0; -32768 has no positive twin and saturates.
  always_comb begin
    neg_x = win_x[15] && (win_x != '0);
    if (win_x == 16'h8000) begin
      abs_x = 16'h7fff;
    end else if (win_x[15]) begin
      abs_x = ~win_x + 16'd1;
    end else begin
      abs_x = win_x;
    end
  end

  // FSM next state plus grant gating and idle indication.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    idle      = 1'b0;
    case (state_q)
      StIdle: begin
        idle = pipe_empty;
        if (en) state_d = StRun;
      end
      StRun: begin
        req_ready = grant;
        if (!en) state_d = StDrain;
      end
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (pipe_empty) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fx_clamp = (sig_fx > OneQ) ? OneQ : sig_fx;

  // State, issue register, tag pipeline and response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= IdW'(N_REQ - 1);
      sig_x_q     <= '0;
      tag_vld_q   <= '0;
      tag_neg_q   <= '0;
      for (int i = 0; i < int'(Depth); i++) tag_id_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_fx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        rr_q    <= win_id;
        sig_x_q <= abs_x;
      end
      tag_vld_q[0] <= hs;
      tag_neg_q[0] <= hs & neg_x;
      tag_id_q[0]  <= win_id;
      for (int i = 1; i < int'(Depth); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_neg_q[i] <= tag_neg_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      // The last tag slot lines up with sig_fx for the operand it describes.
      rsp_valid_q <= tag_vld_q[Depth-1];
      if (tag_vld_q[Depth-1]) begin
        rsp_id_q <= tag_id_q[Depth-1];
        rsp_fx_q <= tag_neg_q[Depth-1] ? (OneQ - fx_clamp) : fx_clamp;
      end
    end
  end

  assign sig_x     = sig_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_fx    = rsp_fx_q;

`ifdef PSOA_SCHED_STATS_EN
  logic [31:0] stat_ops_q, stat_busy_q;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      if (hs && (stat_ops_q != '1)) stat_ops_q <= stat_ops_q + 32'd1;
      if (!pipe_empty && (stat_busy_q != '1)) stat_busy_q <= stat_busy_q + 32'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_psoa_sigmoid_sched.sv
// Self-checking bench for psoa_sigmoid_sched with a behavioural stand-in for the sigmoid unit.
module tb_psoa_sigmoid_sched;

  localparam int N      = 4;
  localparam int SigLat = 1;
  localparam int Lat    = SigLat + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_x = '0;
  logic [N-1:0]    req_ready;
  logic [15:0]     sig_x;
  logic [15:0]     sig_fx = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_fx;
  logic            idle;
`ifdef PSOA_SCHED_STATS_EN
  logic [31:0]     stat_ops, stat_busy;
`endif

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int v;
    int c;
  } ev_t;

  ev_t hs_q[$];
  ev_t rsp_q[$];

  psoa_sigmoid_sched #(.N_REQ(N), .SIG_LAT(SigLat), .ONE_Q(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .sig_x     (sig_x),
    .sig_fx    (sig_fx),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_fx    (rsp_fx),
    .idle      (idle)
`ifdef PSOA_SCHED_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_busy (stat_busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in sigmoid: monotone curve through f(0)=515, f(1)=744, f(4)=1024, overshooting beyond.
  function automatic int ref_sig(int u);
    if (u < 1024) return 515 + (u * 229) / 1024;
    else if (u < 4096) return 744 + ((u - 1024) * 280) / 3072;
    else return 1024 + (u - 4096) / 1024;
  endfunction

  // Expected scheduler result for a signed operand.
  function automatic int exp_fx(int x);
    int u, c;
    u = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
    c = ref_sig(u);
    if (c > 1024) c = 1024;
    return (x < 0) ? 1024 - c : c;
  endfunction

  always @(posedge clk) sig_fx <= 16'(ref_sig(int'(sig_x)));

  // Record handshakes and response strobes with their cycle numbers.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          hs_q.push_back('{id: i, v: int'($signed(req_x[16*i +: 16])), c: cyc});
      end
      if (rsp_valid) rsp_q.push_back('{id: int'(rsp_id), v: int'(rsp_fx), c: cyc});
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    req_valid = '0;
    step(2);
    rst_n = 1'b1;
    hs_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_fx !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid=%b id=%0d fx=%0d want 0/0/0", rsp_valid, rsp_id, rsp_fx);
    end
    n_tests++;
    if (sig_x !== 16'd0 || idle !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got sig_x=%0d idle=%b ready=%b want 0/1/0", sig_x, idle, req_ready);
    end
    req_valid = '1;
    #1;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL idle_no_grant: got ready=%b want 0000", req_ready);
    end
    step(3);
    n_tests++;
    if (req_ready !== '0 || idle !== 1'b1 || hs_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_hold: got ready=%b idle=%b hs=%0d want 0000/1/0", req_ready, idle,
               hs_q.size());
    end
    req_valid = '0;
  endtask

  task automatic test_directed();
    int ids[6] = '{0, 1, 1, 2, 3, 0};
    int xs[6]  = '{0, 1024, -1024, 4096, -4096, -32768};
    int fxs[6] = '{515, 744, 280, 1024, 0, 0};
    int sxs[6] = '{0, 1024, 1024, 4096, 4096, 32767};
    do_reset();
    en = 1'b1;
    step(1);
    for (int k = 0; k < 6; k++) begin
      req_valid = '0;
      req_valid[ids[k]] = 1'b1;
      req_x[16*ids[k] +: 16] = 16'(xs[k]);
      step(1);
      n_tests++;
      if (sig_x !== 16'(sxs[k])) begin
        n_fail++;
        $display("FAIL directed_sig_x[%0d]: got %0d want %0d", k, sig_x, sxs[k]);
      end
    end
    req_valid = '0;
    step(Lat + 3);
    n_tests++;
    if (hs_q.size() != 6 || rsp_q.size() != 6) begin
      n_fail++;
      $display("FAIL directed_count: got hs=%0d rsp=%0d want 6/6", hs_q.size(), rsp_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k >= hs_q.size() || k >= rsp_q.size()) break;
      n_tests++;
      if (rsp_q[k].id != ids[k] || rsp_q[k].v != fxs[k] || rsp_q[k].c != hs_q[k].c + Lat ||
          hs_q[k].c != hs_q[0].c + k) begin
        n_fail++;
        $display("FAIL directed_rsp[%0d]: got id=%0d fx=%0d dly=%0d hs_ofs=%0d want %0d/%0d/%0d/%0d",
                 k, rsp_q[k].id, rsp_q[k].v, rsp_q[k].c - hs_q[k].c, hs_q[k].c - hs_q[0].c,
                 ids[k], fxs[k], Lat, k);
      end
    end
  endtask

  task automatic test_round_robin();
    int xs[N];
    do_reset();
    en = 1'b1;
    step(1);
    for (int i = 0; i < N; i++) begin
      xs[i] = int'($urandom_range(0, 65535)) - 32768;
      req_x[16*i +: 16] = 16'(xs[i]);
    end
    req_valid = '1;
    step(8);
    req_valid = '0;
    step(Lat + 3);
    n_tests++;
    if (hs_q.size() != 8 || rsp_q.size() != 8) begin
      n_fail++;
      $display("FAIL rr_count: got hs=%0d rsp=%0d want 8/8", hs_q.size(), rsp_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      if (k >= hs_q.size() || k >= rsp_q.size()) break;
      n_tests++;
      if (hs_q[k].id != k % N || hs_q[k].c != hs_q[0].c + k || rsp_q[k].id != k % N ||
          rsp_q[k].v != exp_fx(xs[k % N]) || rsp_q[k].c != hs_q[k].c + Lat) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got grant=%0d rsp_id=%0d fx=%0d dly=%0d want %0d/%0d/%0d/%0d",
                 k, hs_q[k].id, rsp_q[k].id, rsp_q[k].v, rsp_q[k].c - hs_q[k].c, k % N, k % N,
                 exp_fx(xs[k % N]), Lat);
      end
    end
`ifdef PSOA_SCHED_STATS_EN
    n_tests++;
    if (stat_ops !== 32'd8 || stat_busy !== 32'd9) begin
      n_fail++;
      $display("FAIL stats: got ops=%0d busy=%0d want 8/9", stat_ops, stat_busy);
    end
`endif
  endtask

  task automatic test_drain();
    int x0, x1;
    do_reset();
    en = 1'b1;
    step(1);
    x0 = int'($urandom_range(0, 65535)) - 32768;
    x1 = int'($urandom_range(0, 65535)) - 32768;
    req_valid = 4'b0001;
    req_x[15:0] = 16'(x0);
    step(1);
    // en falls in the same cycle as the second handshake
    req_valid = 4'b0010;
    req_x[31:16] = 16'(x1);
    en = 1'b0;
    step(1);
    req_valid = '1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_tests++;
      if (req_ready !== '0 || idle !== (k >= Lat + 1)) begin
        n_fail++;
        $display("FAIL drain_cycle[%0d]: got ready=%b idle=%b want 0000/%b", k, req_ready, idle,
                 (k >= Lat + 1));
      end
      step(1);
    end
    req_valid = '0;
    n_tests++;
    if (hs_q.size() != 2 || rsp_q.size() != 2) begin
      n_fail++;
      $display("FAIL drain_count: got hs=%0d rsp=%0d want 2/2", hs_q.size(), rsp_q.size());
    end else begin
      n_tests++;
      if (rsp_q[0].id != 0 || rsp_q[0].v != exp_fx(x0) || rsp_q[1].id != 1 ||
          rsp_q[1].v != exp_fx(x1) || rsp_q[1].c != rsp_q[0].c + 1 ||
          rsp_q[0].c != hs_q[0].c + Lat) begin
        n_fail++;
        $display("FAIL drain_rsp: got %0d:%0d@%0d %0d:%0d@%0d want 0:%0d@%0d 1:%0d@%0d",
                 rsp_q[0].id, rsp_q[0].v, rsp_q[0].c, rsp_q[1].id, rsp_q[1].v, rsp_q[1].c,
                 exp_fx(x0), hs_q[0].c + Lat, exp_fx(x1), hs_q[0].c + Lat + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    step(1);
    req_valid = 4'b0100;
    req_x[47:32] = 16'd0;
    step(1);
    req_valid = '0;
    step(2);
    // rr now points at requester 2; issue again, then pulse reset one cycle later
    req_valid = 4'b0100;
    req_x[47:32] = 16'd1024;
    step(1);
    req_valid = '0;
    rst_n = 1'b0;
    en = 1'b0;
    step(1);
    rst_n = 1'b1;
    rsp_q.delete();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_fx !== 16'd0 || sig_x !== 16'd0 ||
        idle !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got v=%b id=%0d fx=%0d sx=%0d idle=%b rdy=%b want 0/0/0/0/1/0",
               rsp_valid, rsp_id, rsp_fx, sig_x, idle, req_ready);
    end
    step(4);
    n_tests++;
    if (rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_no_rsp: got %0d strobes want 0", rsp_q.size());
    end
    en = 1'b1;
    step(1);
    req_valid = '1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_rr: got ready=%b want 0001", req_ready);
    end
    step(1);
    req_valid = '0;
    step(Lat + 2);
  endtask

  task automatic test_random();
    int mstate, rr_m, last_h, win, r;
    int xv[N];
    logic [N-1:0] v, exp_ready;
    logic pe;
    ev_t exp_q[$];
    do_reset();
    mstate = 0;
    rr_m = N - 1;
    last_h = -100;
    en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 2) != 0);
        r = int'($urandom_range(0, 9));
        xv[i] = (r == 0) ? -32768 : ((r == 1) ? 0 : int'($urandom_range(0, 65535)) - 32768);
        req_x[16*i +: 16] = 16'(xv[i]);
      end
      req_valid = v;
      #1;
      win = -1;
      if (mstate == 1) begin
        for (int k = 1; k <= N; k++) begin
          int cand;
          cand = (rr_m + k) % N;
          if (v[cand]) begin
            win = cand;
            break;
          end
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      pe = (last_h < cyc - 1 - SigLat);
      n_tests++;
      if (req_ready !== exp_ready || idle !== (mstate == 0 && pe)) begin
        n_fail++;
        $display("FAIL rand_cycle[%0d]: got ready=%b idle=%b want %b/%b", t, req_ready, idle,
                 exp_ready, (mstate == 0 && pe));
      end
      if (win >= 0) begin
        exp_q.push_back('{id: win, v: exp_fx(xv[win]), c: cyc + Lat});
        rr_m = win;
        last_h = cyc;
      end
      case (mstate)
        0: if (en) mstate = 1;
        1: if (!en) mstate = 2;
        default: begin
          if (en) mstate = 1;
          else if (pe) mstate = 0;
        end
      endcase
      step(1);
    end
    req_valid = '0;
    step(Lat + 3);
    n_tests++;
    if (rsp_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d responses want %0d", rsp_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= rsp_q.size()) break;
      n_tests++;
      if (rsp_q[k].id != exp_q[k].id || rsp_q[k].v != exp_q[k].v || rsp_q[k].c != exp_q[k].c) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got id=%0d fx=%0d cyc=%0d want %0d/%0d/%0d", k, rsp_q[k].id,
                 rsp_q[k].v, rsp_q[k].c, exp_q[k].id, exp_q[k].v, exp_q[k].c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
